freq_scan_controller: RTL
=========================

# freq_scan_controller

Scan sequencer that time-shares one `frequency_module` between `NUM_PIXELS` light-level sources. It latches each enabled pixel's 8-bit level in turn and drives it onto the frequency module's `INPUT` for a fixed dwell period. It also reports which pixel is being converted, plus frame start/done strobes, so downstream readout can tag `FREQ_OUT` activity. It sits between the pixel array and the frequency module in the fast-readout path.

## Interface
- `NUM_PIXELS`, default 4: number of pixel sources, 2..16.
- `INPUT_BITS`, default 8: light-level width; matches the frequency module's `INPUT_BITS`.
- `DWELL_CYCLES`, default 50: clock cycles each pixel is held on `FREQ_INPUT`; must be ≥1.
- `BLANK_CYCLES`, default 4: gap cycles between pixels; must be ≥1. Used only with `FREQ_SCAN_BLANK_EN`.
- `CLK` in 1: system clock; all logic on the rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `START` in 1: level-sampled; begins a frame when sampled high in IDLE.
- `STOP` in 1: level-sampled; aborts any scan.
- `CONTINUOUS` in 1: sampled at end of frame; 1 means wrap and rescan.
- `PIXEL_MASK` in `NUM_PIXELS`: bit i = 1 includes pixel i. Latched at frame start.
- `PIXELS` in `NUM_PIXELS*INPUT_BITS`: pixel i occupies bits `[i*INPUT_BITS +: INPUT_BITS]`.
- `FREQ_INPUT` out `INPUT_BITS`: drives the frequency module's `INPUT`.
- `PIXEL_IDX` out `max(1,$clog2(NUM_PIXELS))`: index of the pixel currently on `FREQ_INPUT`.
- `PIXEL_VALID` out 1: high while in DWELL.
- `FRAME_START` out 1: 1-cycle pulse when the first pixel of a frame enters DWELL.
- `FRAME_DONE` out 1: 1-cycle pulse at normal frame completion.
- `BUSY` out 1: high in any state other than IDLE.

## Operation
- Reset values: `FREQ_INPUT`=0, `PIXEL_IDX`=0, `PIXEL_VALID`=0, `FRAME_START`=0, `FRAME_DONE`=0, `BUSY`=0. State is IDLE; latched mask is 0; dwell counter is 0.
- States: IDLE, DWELL, BLANK (BLANK exists only with the macro).
- IDLE, `START`=1, `STOP`=0, `PIXEL_MASK`≠0:
  - Latch the mask.
  - Go to DWELL on the lowest enabled index i.
  - Latch `PIXELS[i]` into `FREQ_INPUT`.
  - Pulse `FRAME_START`.
- IDLE, `START`=1, `PIXEL_MASK`=0: pulse `FRAME_DONE` for one cycle; remain IDLE.
- DWELL:
  - `FREQ_INPUT` holds the value latched on entry; later `PIXELS` changes are ignored.
  - The counter runs 0..`DWELL_CYCLES`-1.
  - On the last count, move to the next enabled index above the current one (via BLANK when the macro is defined).
- End of frame (last count of the highest enabled index):
  - Pulse `FRAME_DONE`.
  - If `CONTINUOUS`=1: re-latch `PIXEL_MASK`. If the new mask is nonzero, wrap to its lowest enabled index and pulse `FRAME_START` in the same cycle as `FRAME_DONE`.
  - Otherwise go to IDLE with `FREQ_INPUT`=0.
- `STOP`=1 in any state:
  - Next edge goes to IDLE.
  - `FREQ_INPUT`=0, `PIXEL_VALID`=0.
  - No `FRAME_DONE`.
  - `STOP` wins over a simultaneous `START` or end of frame.
- `START` while `BUSY` is ignored. `PIXEL_MASK` changes mid-frame take effect only at the next frame start or wrap.
- A single enabled pixel with `CONTINUOUS`=1 re-dwells the same pixel indefinitely, pulsing `FRAME_DONE` and `FRAME_START` every `DWELL_CYCLES` cycles (plus blank cycles when enabled).
- `RST_N` low mid-scan: all outputs go to reset values immediately (asynchronously).

## Timing
- `START` sampled at edge k → `BUSY`, `PIXEL_VALID`, `FRAME_START` and the new `FREQ_INPUT` are all valid after edge k; `FRAME_START` is low again after edge k+1.
- Each pixel's `PIXEL_VALID` is high for exactly `DWELL_CYCLES` cycles.
- Without the macro, consecutive pixels are back-to-back: frame length = (enabled count)·`DWELL_CYCLES`.
- With the macro, each transition (including a wrap) adds `BLANK_CYCLES` cycles with `FREQ_INPUT`=0 and `PIXEL_VALID`=0, while `PIXEL_IDX` already shows the next pixel.
- All outputs are registered.

## Configuration
- Macro: `FREQ_SCAN_BLANK_EN`.
- Defined: the BLANK state is inserted between pixels for `BLANK_CYCLES` cycles, forcing a zero-light level so the frequency module settles between pixels.
- Undefined: no BLANK state exists; `BLANK_CYCLES` is ignored and DWELL transitions directly to DWELL.

## Test plan
Default parameters throughout.
- Mask=4'b1111, `PIXELS`={8'h40,8'h30,8'h20,8'h10}, `START` pulse, `CONTINUOUS`=0, no macro:
  - `FREQ_INPUT` sequence 0x10, 0x20, 0x30, 0x40, each held 50 cycles.
  - `FRAME_DONE` at cycle 200.
  - Then `BUSY`=0 and `FREQ_INPUT`=0.
- Mask=4'b1010: only indices 1 and 3 dwell; frame is 100 cycles; `PIXEL_IDX` shows 1 then 3.
- Mask=4'b0001, `CONTINUOUS`=1: `FRAME_DONE` and `FRAME_START` pulse together every 50 cycles. Dropping `CONTINUOUS` stops the scan at the next frame end.
- `STOP` asserted at cycle 75 of a full-mask frame: `BUSY`=0 and `FREQ_INPUT`=0 at cycle 76; no `FRAME_DONE`. `START`+`STOP` together in IDLE leaves the block in IDLE.
- Change `PIXELS[0]` to 0xFF mid-dwell → `FREQ_INPUT` stays 0x10. Mask=0 with `START` → one `FRAME_DONE` pulse, `BUSY` stays 0.
- With `FREQ_SCAN_BLANK_EN`, mask=4'b0011:
  - `FREQ_INPUT` = 0x10 for 50 cycles, 0 for 4 cycles, 0x20 for 50 cycles.
  - `PIXEL_IDX`=1 during the blank.
  - Asserting `RST_N`=0 mid-dwell zeroes all outputs immediately.

Source files
------------

// File: rtl/freq_scan_controller.sv
// rtl/freq_scan_controller.sv - scan sequencer time-sharing one frequency module across pixels
//
// Latches each enabled pixel level in turn onto FREQ_INPUT for DWELL_CYCLES,
// tagging it with PIXEL_IDX and framing the scan with FRAME_START/FRAME_DONE.
//
// Optional feature macro: FREQ_SCAN_BLANK_EN
//   defined   - a BLANK state of BLANK_CYCLES zero-level cycles sits between pixels
//   undefined - pixels are dwelt back to back
//
// Ports:
//   CLK, RST_N   - clock (rising edge), asynchronous active-low reset
//   START        - begin a frame when sampled high in IDLE
//   STOP         - abort any scan, return to IDLE
//   CONTINUOUS   - sampled at frame end: wrap and rescan
//   PIXEL_MASK   - per-pixel enable, latched at frame start / wrap
//   PIXELS       - packed pixel levels, pixel i at [i*INPUT_BITS +: INPUT_BITS]
//   FREQ_INPUT   - level driven to the frequency module
//   PIXEL_IDX    - index of the pixel currently selected
//   PIXEL_VALID  - high while dwelling on a pixel
//   FRAME_START  - 1-cycle pulse when the first pixel of a frame enters DWELL
//   FRAME_DONE   - 1-cycle pulse at normal frame completion
//   BUSY         - high whenever not IDLE
module freq_scan_controller #(
  parameter int NUM_PIXELS   = 4,
  parameter int INPUT_BITS   = 8,
  parameter int DWELL_CYCLES = 50,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                                 CLK,
  input  logic                                 RST_N,
  input  logic                                 START,
  input  logic                                 STOP,
  input  logic                                 CONTINUOUS,
  input  logic [NUM_PIXELS-1:0]                PIXEL_MASK,
  input  logic [NUM_PIXELS*INPUT_BITS-1:0]     PIXELS,
  output logic [INPUT_BITS-1:0]                FREQ_INPUT,
  output logic [(NUM_PIXELS > 1 ? $clog2(NUM_PIXELS) : 1)-1:0] PIXEL_IDX,
  output logic                                 PIXEL_VALID,
  output logic                                 FRAME_START,
  output logic                                 FRAME_DONE,
  output logic                                 BUSY
);

  localparam int IW      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  // One counter serves both the dwell and the blank phase.
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
`ifdef FREQ_SCAN_BLANK_EN
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
`endif

`ifdef FREQ_SCAN_BLANK_EN
  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_BLANK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DWELL} state_t;
`endif

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_PIXELS-1:0]   mask_q, mask_d;
  logic [INPUT_BITS-1:0]   freq_q, freq_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    valid_q, valid_d;
  logic                    fs_q, fs_d;
  logic                    fd_q, fd_d;
  logic                    busy_q, busy_d;
`ifdef FREQ_SCAN_BLANK_EN
  // Remembers that the pixel waiting behind the blank starts a new frame.
  logic                    wrap_q, wrap_d;
`endif

  logic [IW:0]             step;      // {found, index} of next enabled pixel above idx_q
  logic [IW-1:0]           wrap_idx;  // lowest enabled pixel of the live mask
  logic                    advance;
  logic [IW-1:0]           adv_idx;
  logic                    adv_first;

  function automatic logic [IW-1:0] lowest_idx(input logic [NUM_PIXELS-1:0] m);
    lowest_idx = '0;
    for (int i = NUM_PIXELS - 1; i >= 0; i--)
      if (m[i]) lowest_idx = IW'(i);
  endfunction

  function automatic logic [IW:0] next_above(input logic [NUM_PIXELS-1:0] m,
                                             input logic [IW-1:0] cur);
    next_above = '0;
    for (int i = NUM_PIXELS - 1; i >= 0; i--)
      if (m[i] && (i > int'(cur))) next_above = {1'b1, IW'(i)};
  endfunction

  function automatic logic [INPUT_BITS-1:0] pixel_at(input logic [IW-1:0] i);
    pixel_at = PIXELS[int'(i)*INPUT_BITS +: INPUT_BITS];
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      freq_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FREQ_SCAN_BLANK_EN
      wrap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      freq_q  <= freq_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
`ifdef FREQ_SCAN_BLANK_EN
      wrap_q  <= wrap_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    freq_d    = freq_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    fs_d      = 1'b0;
    fd_d      = 1'b0;
    advance   = 1'b0;
    adv_idx   = '0;
    adv_first = 1'b0;
`ifdef FREQ_SCAN_BLANK_EN
    wrap_d    = wrap_q;
`endif
    step      = next_above(mask_q, idx_q);
    wrap_idx  = lowest_idx(PIXEL_MASK);

    if (STOP) begin
      // Abort overrides start and end-of-frame; no FRAME_DONE on abort.
      state_d = S_IDLE;
      cnt_d   = '0;
      freq_d  = '0;
      valid_d = 1'b0;
      idx_d   = '0;
`ifdef FREQ_SCAN_BLANK_EN
      wrap_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            if (|PIXEL_MASK) begin
              // First pixel goes straight to DWELL, never through BLANK.
              mask_d  = PIXEL_MASK;
              idx_d   = wrap_idx;
              freq_d  = pixel_at(wrap_idx);
              valid_d = 1'b1;
              fs_d    = 1'b1;
              cnt_d   = '0;
              state_d = S_DWELL;
            end else begin
              fd_d = 1'b1;
            end
          end
        end
        S_DWELL: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d = '0;
            if (step[IW]) begin
              advance = 1'b1;
              adv_idx = step[IW-1:0];
            end else begin
              fd_d = 1'b1;
              if (CONTINUOUS && (|PIXEL_MASK)) begin
                mask_d    = PIXEL_MASK;
                advance   = 1'b1;
                adv_idx   = wrap_idx;
                adv_first = 1'b1;
              end else begin
                state_d = S_IDLE;
                freq_d  = '0;
                valid_d = 1'b0;
                idx_d   = '0;
              end
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef FREQ_SCAN_BLANK_EN
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d   = '0;
            state_d = S_DWELL;
            freq_d  = pixel_at(idx_q);
            valid_d = 1'b1;
            fs_d    = wrap_q;
            wrap_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end

    if (advance) begin
      idx_d = adv_idx;
`ifdef FREQ_SCAN_BLANK_EN
      // Blank shows the upcoming index but a zero level.
      state_d = S_BLANK;
      freq_d  = '0;
      valid_d = 1'b0;
      wrap_d  = adv_first;
`else
      state_d = S_DWELL;
      freq_d  = pixel_at(adv_idx);
      valid_d = 1'b1;
      fs_d    = adv_first;
`endif
    end

    busy_d = (state_d != S_IDLE);
  end

  assign FREQ_INPUT  = freq_q;
  assign PIXEL_IDX   = idx_q;
  assign PIXEL_VALID = valid_q;
  assign FRAME_START = fs_q;
  assign FRAME_DONE  = fd_q;
  assign BUSY        = busy_q;

endmodule
